merge_pass_sequencer: RTL and testbench
=======================================

Name: merge_pass_sequencer

Overview:
Parametrised control unit for the sorter's iterative merge stage. It accepts a block of N presorted chunks, preloads the merge core through its bypass path, then issues one merge pass per remaining chunk. It tracks the sizes of the incoming chunk and the growing result, and steers the final pass to the output. Successor to the fixed 8-element merger controller: it adds generic chunk size and length, reset, abort, busy/done status and an optional merge watchdog.

Parameters:
MAX_SORT_LENGTH, 256, maximum elements per sort; must be a multiple of BASE_CHUNK_SIZE.
BASE_CHUNK_SIZE, 8, elements per full chunk; power of two, >=2.
START_DELAY, 3, cycles data_in_valid is delayed before it qualifies registered_in_valid; >=1.
BYPASS_LOAD_CYCLES, 7, cycles spent loading the first chunk through the bypass; >=1.
TIMEOUT_CYCLES, 1024, merge watchdog limit; used only with the optional feature.
Derived: SIZE_W = $clog2(MAX_SORT_LENGTH)+1; CNT_W = $clog2(MAX_SORT_LENGTH/BASE_CHUNK_SIZE)+1.

Ports:
clock  in  1  system clock; all logic rising-edge.
reset  in  1  synchronous, active-high reset.
data_in_valid  in  1  raw input-valid from the chunk sorter.
registered_in_valid  in  1  registered input-valid.
n_chunks_in  in  CNT_W  total chunks including a partial one; range 1..MAX_SORT_LENGTH/BASE_CHUNK_SIZE.
last_chunk_size  in  $clog2(BASE_CHUNK_SIZE)  size of the final chunk; 0 means full.
merge_done  in  1  single-cycle completion pulse from the merge core.
abort  in  1  cancels the current sort.
output_selector  out  1  1 = merge core output routed to the stage output.
select_merge_bypass  out  1  1 = bypass path loads the result buffer.
core_start  out  1  single-cycle merge start pulse.
input_chunk_size  out  SIZE_W  size of the chunk being merged.
result_size  out  SIZE_W  size of the result after the current pass.
busy  out  1  high whenever the FSM is not IDLE.
sort_done  out  1  single-cycle pulse when the sort completes.
timeout_error  out  1  watchdog pulse; tied to 0 without the feature.

Behaviour:
- Reset values: output_selector=0, select_merge_bypass=1, core_start=0, input_chunk_size=0, result_size=0, busy=0, sort_done=0, timeout_error=0. Start pipe, counters and FSM cleared. Reset mid-sort returns to IDLE on the next edge.
- Start qualifier: data_in_valid passes through a START_DELAY-deep shift register, which runs only in IDLE. start = registered_in_valid & pipe[START_DELAY-1].
- IDLE: on start with n_chunks_in>=1, latch N and L. first = (N==1 && L!=0) ? L : BASE. Set result_size=first, input_chunk_size=first, merges_left=N-1, go to BYPASS. If start arrives with N==0, ignore it and stay in IDLE.
- BYPASS: count BYPASS_LOAD_CYCLES cycles with select_merge_bypass=1. On the last cycle:
  - merges_left==0: output_selector=1, sort_done pulses next cycle, then IDLE. core_start never asserts.
  - otherwise: select_merge_bypass=0, load the PASS sizes, go to MERGE with core_start=1 for exactly one cycle.
- PASS sizes: input_chunk_size = (merges_left==1 && L!=0) ? L : BASE; result_size += input_chunk_size. Both are stable from the core_start cycle until the next update.
- MERGE: output_selector = (merges_left==1) from the core_start cycle onward. A merge_done coincident with core_start is ignored. On a later merge_done: decrement merges_left, go to UPDATE.
- UPDATE (1 cycle): merges_left==0 -> sort_done=1, output_selector=0, select_merge_bypass=1, go to IDLE. Otherwise load the PASS sizes, pulse core_start, go to MERGE.
- Arithmetic: all sizes are unsigned SIZE_W. result_size never exceeds (N-1)*BASE + (L?L:BASE) <= MAX_SORT_LENGTH, so no wrap is possible.
- abort has priority over every event: next cycle is IDLE with reset output values and no sort_done. Abort in IDLE is a no-op.
- Inputs are ignored while busy. merge_done outside MERGE is ignored.

Optional Feature:
MERGE_WATCHDOG_EN.
- With it: a counter runs in MERGE and clears on core_start. Reaching TIMEOUT_CYCLES without merge_done pulses timeout_error for 1 cycle and performs abort behaviour.
- Without it: no counter is instantiated; timeout_error is constant 0 and MERGE waits indefinitely.

Decomposition:
- Package merger_pkg holds:
  - the FSM enum typedef (IDLE, BYPASS, MERGE, UPDATE, DONE);
  - size_w/cnt_w constant functions;
  - the default BASE_CHUNK_SIZE.
- One sub-module, merger_start_qualifier: the START_DELAY shift register plus the AND with registered_in_valid, cleared by reset/abort.

Test Plan:
- BASE=8, N=4, L=0 -> 3 core_start pulses; input_chunk_size 8,8,8; result_size 16,24,32; output_selector=1 only in pass 3; sort_done 1 cycle after the 3rd UPDATE.
- N=3, L=5 -> input_chunk_size 8 then 5; result_size 16, 21.
- N=1, L=3 -> no core_start; result_size=3; sort_done exactly BYPASS_LOAD_CYCLES+1 cycles after start.
- N=0 with start -> FSM stays IDLE; busy=0; no outputs change.
- abort asserted during pass 2 of N=4 -> next cycle busy=0, reset values, no sort_done; a fresh sort then completes normally.
- MERGE_WATCHDOG_EN, TIMEOUT_CYCLES=16, merge_done withheld -> timeout_error pulses 16 cycles after core_start, FSM IDLE; without the macro the FSM holds in MERGE.

Source files
------------

// File: rtl/merger_pkg.sv
// rtl/merger_pkg.sv - shared types and width helpers for the merge pass sequencer
//
// Contents:
//   merger_state_t           sequencer FSM states
//   size_w()                 width of an element count up to max_sort_length
//   cnt_w()                  width of a chunk count up to max_sort_length/base_chunk_size
//   DEFAULT_BASE_CHUNK_SIZE  elements per full chunk when not overridden
package merger_pkg;

    localparam int DEFAULT_BASE_CHUNK_SIZE = 8;

    typedef enum logic [2:0] {
        IDLE,
        BYPASS,
        MERGE,
        UPDATE,
        DONE
    } merger_state_t;

    function automatic int size_w(input int max_sort_length);
        return $clog2(max_sort_length) + 1;
    endfunction

    function automatic int cnt_w(input int max_sort_length, input int base_chunk_size);
        return $clog2(max_sort_length / base_chunk_size) + 1;
    endfunction

endpackage

// File: rtl/merger_start_qualifier.sv
// rtl/merger_start_qualifier.sv - delays raw input-valid and qualifies it with the registered valid
//
// Ports:
//   clock                in   system clock, rising edge
//   reset                in   synchronous active-high reset, clears the delay pipe
//   clear                in   synchronous clear (abort), clears the delay pipe
//   enable               in   pipe shifts only while high (sequencer idle)
//   data_in_valid        in   raw input-valid from the chunk sorter
//   registered_in_valid  in   registered input-valid
//   start                out  registered_in_valid AND the delayed data_in_valid
module merger_start_qualifier #(
    parameter int START_DELAY = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    input  logic data_in_valid,
    input  logic registered_in_valid,
    output logic start
);

    logic [START_DELAY-1:0] pipe;

    // Shift left so the oldest sample lands in the MSB; the shift form
    // also works for a one-deep pipe.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            pipe <= '0;
        end else if (enable) begin
            pipe <= (pipe << 1) | START_DELAY'(data_in_valid);
        end
    end

    assign start = registered_in_valid & pipe[START_DELAY-1];

endmodule

// File: rtl/merge_pass_sequencer.sv
// rtl/merge_pass_sequencer.sv - control FSM for the sorter's iterative merge stage
//
// Optional feature macro: MERGE_WATCHDOG_EN (merge watchdog, timeout_error)
//
// Ports:
//   clock                in   system clock, rising edge
//   reset                in   synchronous active-high reset
//   data_in_valid        in   raw input-valid from the chunk sorter
//   registered_in_valid  in   registered input-valid
//   n_chunks_in          in   total chunks in the block, partial one included
//   last_chunk_size      in   size of the final chunk, 0 = full
//   merge_done           in   completion pulse from the merge core
//   abort                in   cancels the current sort
//   output_selector      out  1 = merge core output drives the stage output
//   select_merge_bypass  out  1 = bypass path loads the result buffer
//   core_start           out  single-cycle merge start pulse
//   input_chunk_size     out  size of the chunk being merged
//   result_size          out  size of the result after the current pass
//   busy                 out  FSM not idle
//   sort_done            out  single-cycle completion pulse
//   timeout_error        out  watchdog pulse (constant 0 without the watchdog)
module merge_pass_sequencer
    import merger_pkg::*;
#(
    parameter int MAX_SORT_LENGTH    = 256,
    parameter int BASE_CHUNK_SIZE    = DEFAULT_BASE_CHUNK_SIZE,
    parameter int START_DELAY        = 3,
    parameter int BYPASS_LOAD_CYCLES = 7,
    parameter int TIMEOUT_CYCLES     = 1024
) (
    input  logic                                                clock,
    input  logic                                                reset,
    input  logic                                                data_in_valid,
    input  logic                                                registered_in_valid,
    input  logic [cnt_w(MAX_SORT_LENGTH, BASE_CHUNK_SIZE)-1:0]  n_chunks_in,
    input  logic [$clog2(BASE_CHUNK_SIZE)-1:0]                  last_chunk_size,
    input  logic                                                merge_done,
    input  logic                                                abort,
    output logic                                                output_selector,
    output logic                                                select_merge_bypass,
    output logic                                                core_start,
    output logic [size_w(MAX_SORT_LENGTH)-1:0]                  input_chunk_size,
    output logic [size_w(MAX_SORT_LENGTH)-1:0]                  result_size,
    output logic                                                busy,
    output logic                                                sort_done,
    output logic                                                timeout_error
);

    localparam int SIZE_W = size_w(MAX_SORT_LENGTH);
    localparam int CNT_W  = cnt_w(MAX_SORT_LENGTH, BASE_CHUNK_SIZE);
    localparam int L_W    = $clog2(BASE_CHUNK_SIZE);
    localparam int BCNT_W = $clog2(BYPASS_LOAD_CYCLES + 1);
    localparam logic [SIZE_W-1:0] BASE_SIZE = SIZE_W'(BASE_CHUNK_SIZE);

    merger_state_t       state, state_d;
    logic [CNT_W-1:0]    merges_left, merges_left_d;
    logic [L_W-1:0]      last_q, last_d;
    logic [BCNT_W-1:0]   bcnt, bcnt_d;
    logic                output_selector_d, select_merge_bypass_d, core_start_d, sort_done_d;
    logic [SIZE_W-1:0]   input_chunk_size_d, result_size_d;

    logic                start;
    logic                timeout_hit;
    logic [SIZE_W-1:0]   first_size;
    logic [SIZE_W-1:0]   pass_size;
    logic                last_pass;

    merger_start_qualifier #(
        .START_DELAY (START_DELAY)
    ) u_start_qualifier (
        .clock               (clock),
        .reset               (reset),
        .clear               (abort),
        .enable              (state == IDLE),
        .data_in_valid       (data_in_valid),
        .registered_in_valid (registered_in_valid),
        .start               (start)
    );

    // A lone partial chunk is loaded at its own size; otherwise the first
    // chunk through the bypass is always full.
    assign first_size = (n_chunks_in == CNT_W'(1) && last_chunk_size != '0)
                        ? SIZE_W'(last_chunk_size) : BASE_SIZE;

    // merges_left counts passes still to issue, so 1 means this is the pass
    // that merges the (possibly partial) final chunk.
    assign last_pass = (merges_left == CNT_W'(1));
    assign pass_size = (last_pass && last_q != '0) ? SIZE_W'(last_q) : BASE_SIZE;

    assign busy = (state != IDLE);

`ifdef MERGE_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [WD_W-1:0] wd_cnt;

    // wd_cnt equals the number of MERGE cycles elapsed since core_start,
    // so the pulse lands TIMEOUT_CYCLES cycles after core_start.
    assign timeout_hit = (state == MERGE) && !core_start && !merge_done
                         && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            wd_cnt        <= '0;
            timeout_error <= 1'b0;
        end else begin
            timeout_error <= timeout_hit && !abort;
            if (core_start) begin
                wd_cnt <= WD_W'(1);
            end else if (state == MERGE) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end else begin
                wd_cnt <= '0;
            end
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout_hit   = 1'b0;
    assign timeout_error = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state               <= IDLE;
            merges_left         <= '0;
            last_q              <= '0;
            bcnt                <= '0;
            output_selector     <= 1'b0;
            select_merge_bypass <= 1'b1;
            core_start          <= 1'b0;
            sort_done           <= 1'b0;
            input_chunk_size    <= '0;
            result_size         <= '0;
        end else begin
            state               <= state_d;
            merges_left         <= merges_left_d;
            last_q              <= last_d;
            bcnt                <= bcnt_d;
            output_selector     <= output_selector_d;
            select_merge_bypass <= select_merge_bypass_d;
            core_start          <= core_start_d;
            sort_done           <= sort_done_d;
            input_chunk_size    <= input_chunk_size_d;
            result_size         <= result_size_d;
        end
    end

    always_comb begin
        state_d               = state;
        merges_left_d         = merges_left;
        last_d                = last_q;
        bcnt_d                = bcnt;
        output_selector_d     = output_selector;
        select_merge_bypass_d = select_merge_bypass;
        core_start_d          = 1'b0;
        sort_done_d           = 1'b0;
        input_chunk_size_d    = input_chunk_size;
        result_size_d         = result_size;

        case (state)
            IDLE: begin
                if (start && !abort && n_chunks_in != '0) begin
                    state_d               = BYPASS;
                    last_d                = last_chunk_size;
                    merges_left_d         = n_chunks_in - CNT_W'(1);
                    bcnt_d                = '0;
                    input_chunk_size_d    = first_size;
                    result_size_d         = first_size;
                    output_selector_d     = 1'b0;
                    select_merge_bypass_d = 1'b1;
                end
            end
            BYPASS: begin
                if (bcnt == BCNT_W'(BYPASS_LOAD_CYCLES - 1)) begin
                    if (merges_left == '0) begin
                        // Single chunk: the bypassed data is already the result.
                        state_d           = DONE;
                        output_selector_d = 1'b1;
                        sort_done_d       = 1'b1;
                    end else begin
                        state_d               = MERGE;
                        select_merge_bypass_d = 1'b0;
                        core_start_d          = 1'b1;
                        input_chunk_size_d    = pass_size;
                        result_size_d         = result_size + pass_size;
                        output_selector_d     = last_pass;
                    end
                end else begin
                    bcnt_d = bcnt + BCNT_W'(1);
                end
            end
            MERGE: begin
                // A done pulse in the core_start cycle belongs to no pass of ours.
                if (merge_done && !core_start) begin
                    merges_left_d = merges_left - CNT_W'(1);
                    state_d       = UPDATE;
                end
            end
            UPDATE: begin
                if (merges_left == '0) begin
                    state_d               = IDLE;
                    sort_done_d           = 1'b1;
                    output_selector_d     = 1'b0;
                    select_merge_bypass_d = 1'b1;
                end else begin
                    state_d            = MERGE;
                    core_start_d       = 1'b1;
                    input_chunk_size_d = pass_size;
                    result_size_d      = result_size + pass_size;
                    output_selector_d  = last_pass;
                end
            end
            DONE: begin
                state_d               = IDLE;
                output_selector_d     = 1'b0;
                select_merge_bypass_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort (or watchdog expiry) wins over every other event; in IDLE
        // abort leaves the held sizes alone.
        if ((abort && state != IDLE) || timeout_hit) begin
            state_d               = IDLE;
            merges_left_d         = '0;
            last_d                = '0;
            bcnt_d                = '0;
            output_selector_d     = 1'b0;
            select_merge_bypass_d = 1'b1;
            core_start_d          = 1'b0;
            sort_done_d           = 1'b0;
            input_chunk_size_d    = '0;
            result_size_d         = '0;
        end
    end

endmodule

// File: tb/tb_merge_pass_sequencer.sv
// tb/tb_merge_pass_sequencer.sv - self-checking bench for merge_pass_sequencer
module tb_merge_pass_sequencer;

    localparam int CNT_W       = 6;
    localparam int SIZE_W      = 9;
    localparam int L_W         = 3;
    localparam int START_DELAY = 3;
    localparam int BYP         = 7;
    localparam int TMO         = 16;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              data_in_valid = 1'b0;
    logic              registered_in_valid = 1'b1;
    logic [CNT_W-1:0]  n_chunks_in = '0;
    logic [L_W-1:0]    last_chunk_size = '0;
    logic              merge_done = 1'b0;
    logic              abort = 1'b0;
    logic              output_selector, select_merge_bypass, core_start;
    logic [SIZE_W-1:0] input_chunk_size, result_size;
    logic              busy, sort_done, timeout_error;

    merge_pass_sequencer #(
        .MAX_SORT_LENGTH    (256),
        .BASE_CHUNK_SIZE    (8),
        .START_DELAY        (START_DELAY),
        .BYPASS_LOAD_CYCLES (BYP),
        .TIMEOUT_CYCLES     (TMO)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .data_in_valid       (data_in_valid),
        .registered_in_valid (registered_in_valid),
        .n_chunks_in         (n_chunks_in),
        .last_chunk_size     (last_chunk_size),
        .merge_done          (merge_done),
        .abort               (abort),
        .output_selector     (output_selector),
        .select_merge_bypass (select_merge_bypass),
        .core_start          (core_start),
        .input_chunk_size    (input_chunk_size),
        .result_size         (result_size),
        .busy                (busy),
        .sort_done           (sort_done),
        .timeout_error       (timeout_error)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;
    int cs_count = 0;
    int sd_count = 0;
    int last_sd_cycle = -1;
    int last_sd_rs = -1;
    int last_sd_osel = -1;
    int md_auto = 0;
    int cd = 0;

    typedef struct { int ics; int rs; int osel; } pass_t;
    pass_t exp_q[$];

    typedef struct { int n; int l; int md; int exp_final; } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_pass(input int ics, input int rs, input int osel);
        pass_t p;
        p.ics = ics; p.rs = rs; p.osel = osel;
        exp_q.push_back(p);
    endtask

    // Scoreboard: every core_start must match the next expected pass.
    always @(negedge clock) begin : monitor
        pass_t p;
        if (core_start) begin
            cs_count++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_core_start: got 1, required 0 (cycle %0d)", cyc);
            end else begin
                p = exp_q.pop_front();
                check("pass_input_chunk_size", input_chunk_size, p.ics);
                check("pass_result_size", result_size, p.rs);
                check("pass_output_selector", output_selector, p.osel);
                check("pass_bypass_off", select_merge_bypass, 0);
            end
        end
        if (sort_done) begin
            sd_count++;
            last_sd_cycle = cyc;
            last_sd_rs    = int'(result_size);
            last_sd_osel  = int'(output_selector);
        end
    end

    // Merge core model: answers each core_start after md_auto cycles.
    initial begin
        forever begin
            @(negedge clock);
            if (md_auto > 0) begin
                merge_done = 1'b0;
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) merge_done = 1'b1;
                end
                if (core_start) cd = md_auto;
            end
        end
    end

    task automatic goto_cycle(input int x);
        while (cyc < x) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_start(input int n, input int l, output int sc);
        @(posedge clock);
        #1;
        n_chunks_in     = CNT_W'(n);
        last_chunk_size = L_W'(l);
        data_in_valid   = 1'b1;
        sc = cyc + START_DELAY;
        @(posedge clock);
        #1;
        data_in_valid = 1'b0;
    endtask

    task automatic pulse_md(input int x);
        goto_cycle(x);
        merge_done = 1'b1;
        @(posedge clock);
        #1;
        merge_done = 1'b0;
    endtask

    task automatic run_sort(input int n, input int l, input int md, input int exp_final);
        int sc, cs0, sd0, first, rs, ml, ics, exp_cycle;
        first = (n == 1 && l != 0) ? l : 8;
        rs = first;
        ml = n - 1;
        while (ml > 0) begin
            ics = (ml == 1 && l != 0) ? l : 8;
            rs += ics;
            push_pass(ics, rs, (ml == 1) ? 1 : 0);
            ml--;
        end
        cs0 = cs_count;
        sd0 = sd_count;
        cd = 0;
        md_auto = md;
        do_start(n, l, sc);
        goto_cycle(sc + 1);
        @(negedge clock);
        check("bypass_busy", busy, 1);
        check("bypass_select", select_merge_bypass, 1);
        check("bypass_first_size", result_size, first);
        for (int i = 0; i < 3000 && sd_count == sd0; i++) begin
            @(posedge clock);
            #1;
        end
        check("sort_done_count", sd_count - sd0, 1);
        exp_cycle = sc + BYP + 1 + (n - 1) * (md + 2);
        check("sort_done_cycle", last_sd_cycle, exp_cycle);
        check("final_result_size", last_sd_rs, exp_final);
        check("final_output_selector", last_sd_osel, (n == 1) ? 1 : 0);
        check("core_start_count", cs_count - cs0, n - 1);
        check("scoreboard_empty", exp_q.size(), 0);
        goto_cycle(cyc + 2);
        @(negedge clock);
        check("idle_after_done", busy, 0);
        md_auto = 0;
        merge_done = 1'b0;
    endtask

    initial begin : global_limit
        #2000000;
        $display("FAIL global_time_limit: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin : main
        int sc, c1, cs0, sd0, bad;

        vecs[0] = '{n: 4,  l: 0, md: 1, exp_final: 32};
        vecs[1] = '{n: 3,  l: 5, md: 2, exp_final: 21};
        vecs[2] = '{n: 1,  l: 3, md: 1, exp_final: 3};
        vecs[3] = '{n: 1,  l: 0, md: 1, exp_final: 8};
        vecs[4] = '{n: 2,  l: 7, md: 3, exp_final: 15};
        vecs[5] = '{n: 5,  l: 4, md: 1, exp_final: 36};
        vecs[6] = '{n: 32, l: 0, md: 1, exp_final: 256};
        vecs[7] = '{n: 32, l: 1, md: 2, exp_final: 249};

        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("reset_output_selector", output_selector, 0);
        check("reset_select_bypass", select_merge_bypass, 1);
        check("reset_core_start", core_start, 0);
        check("reset_input_chunk_size", input_chunk_size, 0);
        check("reset_result_size", result_size, 0);
        check("reset_busy", busy, 0);
        check("reset_sort_done", sort_done, 0);
        check("reset_timeout_error", timeout_error, 0);

        // Start with zero chunks is ignored.
        do_start(0, 0, sc);
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            if (busy || core_start || sort_done || result_size != '0 || !select_merge_bypass) bad++;
        end
        check("n0_idle_violations", bad, 0);

        foreach (vecs[i]) run_sort(vecs[i].n, vecs[i].l, vecs[i].md, vecs[i].exp_final);

        // merge_done in BYPASS and coincident with core_start is ignored.
        push_pass(8, 16, 1);
        cs0 = cs_count;
        sd0 = sd_count;
        md_auto = 0;
        do_start(2, 0, sc);
        c1 = sc + BYP + 1;
        pulse_md(sc + 3);
        pulse_md(c1);
        goto_cycle(c1 + 4);
        @(negedge clock);
        check("coinc_still_busy", busy, 1);
        check("coinc_pass_count", cs_count - cs0, 1);
        check("coinc_no_done", sd_count - sd0, 0);
        pulse_md(c1 + 5);
        goto_cycle(c1 + 8);
        check("coinc_done_cycle", last_sd_cycle, c1 + 7);
        check("coinc_done_count", sd_count - sd0, 1);

        // Abort during pass 2 of N=4, coincident with that pass's merge_done.
        push_pass(8, 16, 0);
        push_pass(8, 24, 0);
        cs0 = cs_count;
        sd0 = sd_count;
        cd = 0;
        md_auto = 1;
        do_start(4, 0, sc);
        goto_cycle(sc + BYP + 5);
        abort = 1'b1;
        @(posedge clock);
        #1;
        abort = 1'b0;
        @(negedge clock);
        check("abort_busy", busy, 0);
        check("abort_output_selector", output_selector, 0);
        check("abort_select_bypass", select_merge_bypass, 1);
        check("abort_core_start", core_start, 0);
        check("abort_input_chunk_size", input_chunk_size, 0);
        check("abort_result_size", result_size, 0);
        goto_cycle(cyc + 20);
        check("abort_no_sort_done", sd_count - sd0, 0);
        check("abort_pass_count", cs_count - cs0, 2);
        check("abort_scoreboard_empty", exp_q.size(), 0);
        md_auto = 0;
        merge_done = 1'b0;
        run_sort(4, 0, 1, 32);

        // Reset mid-sort.
        do_start(3, 0, sc);
        goto_cycle(sc + 4);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("midreset_busy", busy, 0);
        check("midreset_result_size", result_size, 0);
        check("midreset_select_bypass", select_merge_bypass, 1);

        // merge_done withheld.
        push_pass(8, 16, 1);
        md_auto = 0;
        sd0 = sd_count;
        do_start(2, 0, sc);
        c1 = sc + BYP + 1;
`ifdef MERGE_WATCHDOG_EN
        goto_cycle(c1 + TMO - 1);
        @(negedge clock);
        check("wd_before_limit_err", timeout_error, 0);
        check("wd_before_limit_busy", busy, 1);
        goto_cycle(c1 + TMO);
        @(negedge clock);
        check("wd_timeout_pulse", timeout_error, 1);
        check("wd_idle_after", busy, 0);
        check("wd_result_cleared", result_size, 0);
        goto_cycle(c1 + TMO + 1);
        @(negedge clock);
        check("wd_pulse_single", timeout_error, 0);
`else
        goto_cycle(c1 + 40);
        @(negedge clock);
        check("hold_busy", busy, 1);
        check("hold_no_timeout", timeout_error, 0);
        check("hold_result_size", result_size, 16);
        abort = 1'b1;
        @(posedge clock);
        #1;
        abort = 1'b0;
        @(negedge clock);
        check("hold_abort_idle", busy, 0);
`endif
        check("withheld_no_done", sd_count - sd0, 0);
        check("final_scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
